// File: rtl/apb_stream_mailbox.sv
// APB3 mailbox slave: TX byte FIFO (APB -> core stream), RX byte FIFO (core stream -> APB),
// sticky overflow/underflow flags and eight scratch registers.
module apb_stream_mailbox #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       PSEL,
    input  logic [4:0] PADDR,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic [7:0] tx_tdata,
    output logic       tx_tvalid,
    input  logic       tx_tready,
    input  logic [7:0] rx_tdata,
    input  logic       rx_tvalid,
    output logic       rx_tready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [AW-1:0] PTR1_C  = AW'(1);

    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [7:0]    scratch_q [8];
    logic [AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [AW-1:0] tx_wr_d, tx_rd_d, rx_wr_d, rx_rd_d;
    logic [CW-1:0] tx_cnt_q, rx_cnt_q, tx_cnt_d, rx_cnt_d;
    logic          tx_ovf_q, rx_unf_q, tx_ovf_d, rx_unf_d;
    logic          pready_q, pready_d, rd_empty_q, rd_empty_d;
    logic [7:0]    prdata_q, prdata_d, rdata_s, status_s;

    logic tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic apb_done_s, wr_done_s, rd_done_s, rd_wait_s;
    logic tx_push_s, tx_pop_s, rx_push_s, rx_pop_s, w1c_s, scr_sel_s;

    assign tx_full_s  = (tx_cnt_q == DEPTH_C);
    assign tx_empty_s = (tx_cnt_q == ZERO_C);
    assign rx_full_s  = (rx_cnt_q == DEPTH_C);
    assign rx_empty_s = (rx_cnt_q == ZERO_C);

    assign apb_done_s = PSEL & PENABLE & pready_q;
    assign wr_done_s  = apb_done_s & PWRITE;
    assign rd_done_s  = apb_done_s & ~PWRITE;
    assign rd_wait_s  = PSEL & PENABLE & ~PWRITE & ~pready_q;
    assign scr_sel_s  = (PADDR[4:3] == 2'b01);

    // A full FIFO blocks its push side even if a pop happens in the same cycle.
    assign tx_push_s = wr_done_s & (PADDR == 5'h01) & ~tx_full_s;
    assign tx_pop_s  = ~tx_empty_s & tx_tready;
    assign rx_push_s = rx_tvalid & ~rx_full_s;
    assign rx_pop_s  = rd_done_s & (PADDR == 5'h02) & ~rd_empty_q;
    assign w1c_s     = wr_done_s & (PADDR == 5'h00);

    assign status_s = {2'b00, rx_unf_q, tx_ovf_q, tx_full_s, tx_empty_s, rx_full_s, rx_empty_s};

    assign PRDATA    = prdata_q;
    assign PREADY    = pready_q & PSEL;
    assign tx_tdata  = tx_mem_q[tx_rd_q];
    assign tx_tvalid = ~tx_empty_s;
    assign rx_tready = ~rx_full_s;

    // Read data mux, sampled into prdata_q during the read wait cycle.
    always_comb begin
        rdata_s = 8'h00;
        case (PADDR)
            5'h00:   rdata_s = status_s;
            5'h02:   rdata_s = rx_empty_s ? 8'h00 : rx_mem_q[rx_rd_q];
            5'h03:   rdata_s = 8'(rx_cnt_q);
            5'h04:   rdata_s = 8'(tx_cnt_q);
            default: begin
                if (scr_sel_s) begin
                    rdata_s = scratch_q[PADDR[2:0]];
                end else begin
                    rdata_s = 8'h00;
                end
            end
        endcase
    end

    // Next-state for pointers, occupancy counters, sticky flags and APB handshake.
    always_comb begin
        tx_wr_d = tx_push_s ? tx_wr_q + PTR1_C : tx_wr_q;
        tx_rd_d = tx_pop_s  ? tx_rd_q + PTR1_C : tx_rd_q;
        rx_wr_d = rx_push_s ? rx_wr_q + PTR1_C : rx_wr_q;
        rx_rd_d = rx_pop_s  ? rx_rd_q + PTR1_C : rx_rd_q;
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_cnt_d = tx_cnt_q + ONE_C;
            2'b01:   tx_cnt_d = tx_cnt_q - ONE_C;
            default: tx_cnt_d = tx_cnt_q;
        endcase
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_cnt_d = rx_cnt_q + ONE_C;
            2'b01:   rx_cnt_d = rx_cnt_q - ONE_C;
            default: rx_cnt_d = rx_cnt_q;
        endcase
        // Set wins over a same-cycle write-1-to-clear.
        tx_ovf_d = (tx_ovf_q & ~(w1c_s & PWDATA[4]))
                 | (wr_done_s & (PADDR == 5'h01) & tx_full_s);
        rx_unf_d = (rx_unf_q & ~(w1c_s & PWDATA[5]))
                 | (rd_done_s & (PADDR == 5'h02) & rd_empty_q);
        // Writes complete in the first access cycle, reads after one wait cycle.
        pready_d   = (PSEL & ~PENABLE & PWRITE) | rd_wait_s;
        rd_empty_d = rd_wait_s ? rx_empty_s : rd_empty_q;
        if (rd_wait_s) begin
            prdata_d = rdata_s;
        end else begin
            prdata_d = prdata_q;
        end
    end

    // State registers, FIFO storage and scratch registers.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tx_mem_q[i] <= 8'h00;
                rx_mem_q[i] <= 8'h00;
            end
            for (int i = 0; i < 8; i++) begin
                scratch_q[i] <= 8'h00;
            end
            tx_wr_q    <= {AW{1'b0}};
            tx_rd_q    <= {AW{1'b0}};
            rx_wr_q    <= {AW{1'b0}};
            rx_rd_q    <= {AW{1'b0}};
            tx_cnt_q   <= ZERO_C;
            rx_cnt_q   <= ZERO_C;
            tx_ovf_q   <= 1'b0;
            rx_unf_q   <= 1'b0;
            pready_q   <= 1'b0;
            rd_empty_q <= 1'b0;
            prdata_q   <= 8'h00;
        end else begin
            if (tx_push_s) begin
                tx_mem_q[tx_wr_q] <= PWDATA;
            end
            if (rx_push_s) begin
                rx_mem_q[rx_wr_q] <= rx_tdata;
            end
            if (wr_done_s && scr_sel_s) begin
                scratch_q[PADDR[2:0]] <= PWDATA;
            end
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_unf_q   <= rx_unf_d;
            pready_q   <= pready_d;
            rd_empty_q <= rd_empty_d;
            prdata_q   <= prdata_d;
        end
    end
endmodule
